// File: rtl/io_tx_buffer.sv
// CPU-to-UART output byte FIFO with stop-port handling and back-pressure.
// Define IO_TX_OVERFLOW_CNT_EN to build the dropped-byte counter.
module io_tx_buffer #(
  parameter int DEPTH_LOG2  = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_stop,
  output logic [7:0]  overflow_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int FULL_LVL_I = DEPTH - FULL_MARGIN;
  localparam logic [DEPTH_LOG2:0] DEPTH_C =
    DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] FULL_LVL =
    FULL_LVL_I[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] ONE_C =
    {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RUN,
    STOPPING,
    STOPPED
  } state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   count;

  logic       io_hit;
  logic       stop_sel;
  logic       push_req;
  logic [7:0] push_byte;
  logic       pop;
  logic       full;
  logic       push;
  logic       unused_addr;

  assign io_hit    = rdy_in && mem_wr && (mem_a[17:16] == 2'b11);
  assign stop_sel  = mem_a[2];
  assign push_req  = io_hit && (state == RUN) &&
                     (stop_sel || (mem_dout != 8'h00));
  assign push_byte = stop_sel ? 8'h00 : mem_dout;
  assign pop       = tx_valid && tx_ready;
  assign full      = (count == DEPTH_C);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push      = push_req && (!full || pop);

  assign unused_addr = ^{mem_a[31:18], mem_a[15:3], mem_a[1:0]};

  assign tx_valid       = (count != '0);
  assign tx_data        = tx_valid ? mem[rd_ptr] : 8'h00;
  assign io_buffer_full = (count >= FULL_LVL);
  assign program_stop   = (state == STOPPED);

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= push_byte;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stop request moves on even when its terminator byte was dropped.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (io_hit && stop_sel) begin
            state <= STOPPING;
          end
        end
        STOPPING: begin
          if (pop && (count == ONE_C)) begin
            state <= STOPPED;
          end
        end
        default: state <= STOPPED;
      endcase
    end
  end

`ifdef IO_TX_OVERFLOW_CNT_EN
  logic       drop;
  logic [7:0] ovf_q;

  assign drop = push_req && !push;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ovf_q <= 8'h00;
    end else if (drop && (ovf_q != 8'hFF)) begin
      ovf_q <= ovf_q + 8'h01;
    end
  end

  assign overflow_cnt = ovf_q;
`else
  assign overflow_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_io_tx_buffer.sv
// Directed self-checking bench for io_tx_buffer.
// Overflow expectations follow IO_TX_OVERFLOW_CNT_EN.
module tb_io_tx_buffer;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] a;
  logic [7:0]  dout;
  logic        wr;
  logic        full;
  logic [7:0]  txd;
  logic        txv;
  logic        txr;
  logic        stop;
  logic [7:0]  ovf;

  int checks = 0;
  int failures = 0;

`ifdef IO_TX_OVERFLOW_CNT_EN
  localparam logic [7:0] OVF1 = 8'd1;
`else
  localparam logic [7:0] OVF1 = 8'd0;
`endif

  io_tx_buffer dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .mem_a(a),
    .mem_dout(dout),
    .mem_wr(wr),
    .io_buffer_full(full),
    .tx_data(txd),
    .tx_valid(txv),
    .tx_ready(txr),
    .program_stop(stop),
    .overflow_cnt(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_bus(input logic [31:0] ad,
                        input logic [7:0] d);
    a = ad;
    dout = d;
    wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (txv !== 1'b0) begin
      $display("FAIL reset_txv got=%b exp=0", txv);
      failures++;
    end
    checks++;
    if (txd !== 8'h00) begin
      $display("FAIL reset_txd got=%h exp=00", txd);
      failures++;
    end
    checks++;
    if ({full, stop} !== 2'b00) begin
      $display("FAIL reset_flags got=%b exp=00", {full, stop});
      failures++;
    end
    checks++;
    if (ovf !== 8'h00) begin
      $display("FAIL reset_ovf got=%h exp=00", ovf);
      failures++;
    end
  endtask

  task automatic test_basic();
    txr = 1'b1;
    wr_bus(32'h30000, 8'h41);
    checks++;
    if ({txv, txd} !== {1'b1, 8'h41}) begin
      $display("FAIL basic_a got=%b/%h exp=1/41", txv, txd);
      failures++;
    end
    wr_bus(32'h30000, 8'h42);
    checks++;
    if ({txv, txd} !== {1'b1, 8'h42}) begin
      $display("FAIL basic_b got=%b/%h exp=1/42", txv, txd);
      failures++;
    end
    tick();
    checks++;
    if (txv !== 1'b0) begin
      $display("FAIL basic_empty got=%b exp=0", txv);
      failures++;
    end
  endtask

  task automatic test_ignored();
    int bad;
    bad = 0;
    txr = 1'b1;
    wr_bus(32'h30000, 8'h00);
    if (txv !== 1'b0) bad++;
    rdy = 1'b0;
    wr_bus(32'h30000, 8'h55);
    rdy = 1'b1;
    if (txv !== 1'b0) bad++;
    wr_bus(32'h20000, 8'h66);
    if (txv !== 1'b0) bad++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (txv !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL ignored_txv got=%0d exp=0", bad);
      failures++;
    end
  endtask

  task automatic test_full();
    int bad;
    txr = 1'b0;
    for (int i = 0; i < 13; i++) begin
      wr_bus(32'h30000, 8'h10 + 8'(i));
    end
    checks++;
    if (full !== 1'b0) begin
      $display("FAIL full_13 got=%b exp=0", full);
      failures++;
    end
    wr_bus(32'h30000, 8'h1D);
    checks++;
    if (full !== 1'b1) begin
      $display("FAIL full_14 got=%b exp=1", full);
      failures++;
    end
    wr_bus(32'h30000, 8'h1E);
    wr_bus(32'h30000, 8'h1F);
    wr_bus(32'h30000, 8'h20);
    checks++;
    if (ovf !== OVF1) begin
      $display("FAIL full_ovf got=%h exp=%h", ovf, OVF1);
      failures++;
    end
    txr = 1'b1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if ({txv, txd} !== {1'b1, 8'h10 + 8'(i)}) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL full_drain got=%0d exp=0", bad);
      failures++;
    end
    checks++;
    if ({txv, full} !== 2'b00) begin
      $display("FAIL full_after got=%b exp=00", {txv, full});
      failures++;
    end
  endtask

  task automatic test_full_simul();
    int bad;
    txr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_bus(32'h30000, 8'h80 + 8'(i));
    end
    txr = 1'b1;
    wr_bus(32'h30000, 8'h33);
    checks++;
    if ({full, txd} !== {1'b1, 8'h81}) begin
      $display("FAIL simul_head got=%b/%h exp=1/81", full, txd);
      failures++;
    end
    checks++;
    if (ovf !== OVF1) begin
      $display("FAIL simul_ovf got=%h exp=%h", ovf, OVF1);
      failures++;
    end
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      if ({txv, txd} !== {1'b1, 8'h80 + 8'(i)}) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL simul_drain got=%0d exp=0", bad);
      failures++;
    end
    checks++;
    if ({txv, txd} !== {1'b1, 8'h33}) begin
      $display("FAIL simul_last got=%b/%h exp=1/33", txv, txd);
      failures++;
    end
    tick();
    checks++;
    if (txv !== 1'b0) begin
      $display("FAIL simul_empty got=%b exp=0", txv);
      failures++;
    end
  endtask

  task automatic test_stop();
    int bad;
    txr = 1'b1;
    wr_bus(32'h30000, 8'h61);
    checks++;
    if ({txv, txd, stop} !== {1'b1, 8'h61, 1'b0}) begin
      $display("FAIL stop_a got=%b/%h/%b exp=1/61/0",
               txv, txd, stop);
      failures++;
    end
    wr_bus(32'h30004, 8'hAB);
    checks++;
    if ({txv, txd, stop} !== {1'b1, 8'h00, 1'b0}) begin
      $display("FAIL stop_term got=%b/%h/%b exp=1/00/0",
               txv, txd, stop);
      failures++;
    end
    wr_bus(32'h30000, 8'h62);
    checks++;
    if ({txv, stop} !== 2'b01) begin
      $display("FAIL stop_rise got=%b exp=01", {txv, stop});
      failures++;
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      wr_bus(32'h30000, 8'h77);
      if ({txv, stop} !== 2'b01) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL stop_hold got=%0d exp=0", bad);
      failures++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    txr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_bus(32'h30000, 8'hC0 + 8'(i));
    end
    wr_bus(32'h30004, 8'h00);
    checks++;
    if ({txv, txd} !== {1'b1, 8'hC0}) begin
      $display("FAIL mid_pre got=%b/%h exp=1/c0", txv, txd);
      failures++;
    end
    do_reset();
    checks++;
    if ({txv, stop, full} !== 3'b000) begin
      $display("FAIL mid_rst got=%b exp=000",
               {txv, stop, full});
      failures++;
    end
    wr_bus(32'h30000, 8'hA5);
    checks++;
    if ({txv, txd} !== {1'b1, 8'hA5}) begin
      $display("FAIL mid_new got=%b/%h exp=1/a5", txv, txd);
      failures++;
    end
    txr = 1'b1;
    tick();
    checks++;
    if ({txv, stop} !== 2'b00) begin
      $display("FAIL mid_drain got=%b exp=00", {txv, stop});
      failures++;
    end
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    a = 32'h0;
    dout = 8'h00;
    wr = 1'b0;
    txr = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_ignored();
    test_full();
    test_full_simul();
    test_stop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/io_tx_buffer.md
Name: io_tx_buffer

Overview:
- Sits directly downstream of the CPU memory bus (mem_a / mem_dout / mem_wr) and upstream of the UART transmitter.
- Captures CPU byte writes to the memory-mapped output port 0x30000 and the stop port 0x30004, and buffers them in a FIFO.
- Drains the FIFO to the UART over a valid/ready handshake.
- Produces the io_buffer_full back-pressure flag the CPU consumes, and the program-stop indication.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO entries (16 bytes).
- FULL_MARGIN, 2, io_buffer_full asserts when free entries <= FULL_MARGIN; covers CPU reaction latency.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  CPU ready; bus capture qualified by it
- mem_a  input  32  CPU address bus
- mem_dout  input  8  CPU write data
- mem_wr  input  1  CPU write strobe (1 = write)
- io_buffer_full  output  1  back-pressure to CPU
- tx_data  output  8  byte to UART
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  UART accepts byte when high with tx_valid
- program_stop  output  1  level; high once stop byte has left the FIFO
- overflow_cnt  output  8  dropped-byte counter (see Optional Feature)

Behaviour:
- One clock domain, clk_in. rst_in is synchronous and active-high.
- Reset values: count = 0, read/write pointers = 0, state = RUN, tx_valid = 0, tx_data = 0, io_buffer_full = 0, program_stop = 0, overflow_cnt = 0.
- IO hit condition: rdy_in && mem_wr && mem_a[17:16] == 2'b11. Port select is mem_a[2]: 0 = data port, 1 = stop port. Other address bits are ignored.
- Data port write in state RUN:
  - mem_dout == 8'h00: ignored.
  - Otherwise push mem_dout.
- Stop port write in state RUN: push 8'h00 and go to state STOPPING.
- In STOPPING and STOPPED, all bus writes are ignored (no push, no overflow count).
- Push into a full FIFO: byte dropped, pointers unchanged, overflow_cnt increments, saturating at 8'hFF. A stop-port push that is dropped still moves to STOPPING.
- Drain side:
  - tx_valid = (count != 0) and tx_data = mem[rd_ptr]; both are combinational from registers.
  - Pop when tx_valid && tx_ready.
  - Draining is independent of rdy_in.
- Latency: a byte pushed in cycle N is visible on tx_valid/tx_data in cycle N+1.
- Simultaneous push and pop:
  - Allowed; count is unchanged.
  - When the FIFO is full, a simultaneous pop makes room, so the push is accepted (not dropped).
  - When the FIFO is empty, the pushed byte appears in the next cycle (no same-cycle bypass).
- Pointers are DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2. count is DEPTH_LOG2+1 bits, range 0..2^DEPTH_LOG2.
- io_buffer_full = (count >= 2^DEPTH_LOG2 - FULL_MARGIN). It is combinational from the count register, so it updates one cycle after the push/pop that changed count.
- States:
  - RUN: accepts writes.
  - STOPPING: waits until the 8'h00 terminator is popped, i.e. the pop takes count 1 -> 0; then goes to STOPPED.
  - STOPPED: program_stop = 1. Terminal until reset; tx_valid stays 0.
- Reset mid-operation: FIFO contents are discarded and the block returns to RUN with all outputs at their reset values in the next cycle.

Optional Feature:
- Macro: IO_TX_OVERFLOW_CNT_EN.
- Defined: overflow_cnt implemented as described above.
- Not defined: no counter register; overflow_cnt tied to 8'h00. Drops still occur silently.

Test Plan:
- Write 'A' (0x41), 'B' (0x42) to 0x30000 in consecutive cycles with tx_ready = 1 -> tx_data 0x41 then 0x42 on consecutive cycles, starting one cycle after the first write; count returns to 0.
- Write 0x00 to 0x30000, and write 0x55 with rdy_in = 0 -> no tx_valid ever asserted.
- tx_ready = 0, write 14 bytes -> io_buffer_full = 1 after the 14th push (DEPTH_LOG2 = 4, FULL_MARGIN = 2). Write 3 more -> 2 accepted, 1 dropped, overflow_cnt = 1. Release tx_ready -> exactly 16 bytes drained in order.
- FIFO full, tx_ready = 1, push 0x33 in the same cycle -> byte not dropped, count stays 16, 0x33 emerges last.
- Write 0x61 to 0x30000, then any value to 0x30004, then 0x62 to 0x30000 -> UART receives 0x61 then 0x00 (0x62 ignored); program_stop rises one cycle after the 0x00 pop and stays high.
- Assert rst_in while 5 bytes are queued and in STOPPING -> next cycle tx_valid = 0, program_stop = 0, io_buffer_full = 0; a new 0x30000 write is accepted.
